// File: rtl/spi_mem_pkg.sv
// Shared constants and state encoding for the SPI memory controller.
package spi_mem_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_WRMR  = 8'h01;
    localparam logic [7:0] MODE_BYTE = 8'h00;

    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = 8;
    localparam int DIV_CNT_W = 8;

    typedef enum logic [2:0] {IDLE, INIT, CMD, ADDR, DATA, DONE} state_t;

endpackage

// File: rtl/spi_mem_ctrl_sck_gen.sv
// SCK divider: CLK_DIV cycles low then CLK_DIV cycles high while enabled.
// rise_tick/fall_tick flag the clk edge on which SCK will toggle.
module spi_sck_gen
    import spi_mem_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck,
    output logic fall_tick,
    output logic rise_tick
);

    logic [DIV_CNT_W-1:0] div_cnt;
    logic                 phase_end;

    assign phase_end = en && (div_cnt == DIV_CNT_W'(CLK_DIV - 1));
    assign rise_tick = phase_end && !sck;
    assign fall_tick = phase_end && sck;

    // Dropping en parks SCK low and rewinds the phase so every frame starts clean.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (phase_end) begin
            div_cnt <= '0;
            sck     <= ~sck;
        end else begin
            div_cnt <= div_cnt + DIV_CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_mem_ctrl.sv
// 23LC-style SPI master: opcode, address, data byte in mode 0 per CPU request.
// Optional SPI_MEM_MODE_INIT_EN issues a WRMR (byte mode) frame after reset.
module spi_mem_ctrl
    import spi_mem_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              busy,
    output logic              spi_cs_n,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int TX_W = 2 * BYTE_W + ADDR_W;

    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
        $error("spi_mem_ctrl: CLK_DIV must be in 1..255");
    end

    state_t               state;
    logic [TX_W-1:0]      tx_sr;
    logic [BYTE_W-1:0]    rx_sr;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 we_q;
    logic                 init_q;
    logic                 phase_last;
    logic                 sck_en;
    logic                 fall_tick;
    logic                 rise_tick;

    assign busy   = ~req_ready;
    assign sck_en = (state == CMD) || (state == ADDR) || (state == DATA);

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (sck_en),
        .sck       (spi_sck),
        .fall_tick (fall_tick),
        .rise_tick (rise_tick)
    );

    always_comb begin
        phase_last = 1'b0;
        case (state)
            CMD, DATA: phase_last = (bit_cnt == BIT_CNT_W'(BYTE_W - 1));
            ADDR:      phase_last = (bit_cnt == BIT_CNT_W'(ADDR_W - 1));
            default:   phase_last = 1'b0;
        endcase
    end

    // tx_sr is loaded pre-shifted: the first MOSI bit goes out with the load,
    // every falling-SCK edge presents the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef SPI_MEM_MODE_INIT_EN
            state     <= INIT;
            req_ready <= 1'b0;
`else
            state     <= IDLE;
            req_ready <= 1'b1;
`endif
            spi_cs_n  <= 1'b1;
            spi_mosi  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            tx_sr     <= '0;
            rx_sr     <= '0;
            bit_cnt   <= '0;
            we_q      <= 1'b0;
            init_q    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
`ifdef SPI_MEM_MODE_INIT_EN
                INIT: begin
                    tx_sr    <= {CMD_WRMR[6:0], MODE_BYTE, {ADDR_W{1'b0}}, 1'b0};
                    spi_mosi <= CMD_WRMR[7];
                    spi_cs_n <= 1'b0;
                    we_q     <= 1'b1;
                    init_q   <= 1'b1;
                    bit_cnt  <= '0;
                    state    <= CMD;
                end
`endif
                IDLE: begin
                    if (req_valid) begin
                        tx_sr     <= {(req_we ? CMD_WRITE[6:0] : CMD_READ[6:0]), req_addr,
                                      (req_we ? req_wdata : 8'h00), 1'b0};
                        spi_mosi  <= req_we ? CMD_WRITE[7] : CMD_READ[7];
                        spi_cs_n  <= 1'b0;
                        we_q      <= req_we;
                        req_ready <= 1'b0;
                        bit_cnt   <= '0;
                        state     <= CMD;
                    end
                end
                CMD, ADDR, DATA: begin
                    if (rise_tick && state == DATA)
                        rx_sr <= {rx_sr[BYTE_W-2:0], spi_miso};
                    if (fall_tick) begin
                        spi_mosi <= tx_sr[TX_W-1];
                        tx_sr    <= tx_sr << 1;
                        bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
                        if (phase_last) begin
                            bit_cnt <= '0;
                            case (state)
                                CMD:     state <= init_q ? DATA : ADDR;
                                ADDR:    state <= DATA;
                                default: begin
                                    state     <= DONE;
                                    spi_cs_n  <= 1'b1;
                                    spi_mosi  <= 1'b0;
                                    rsp_valid <= ~init_q;
                                    if (!we_q)
                                        rsp_rdata <= rx_sr;
                                end
                            endcase
                        end
                    end
                end
                DONE: begin
                    req_ready <= 1'b1;
                    init_q    <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed + randomized bench for spi_mem_ctrl against a behavioural SPI memory
// and a byte-array reference model.
module tb_spi_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        busy;
    logic        spi_cs_n;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    always #5 clk = ~clk;

    spi_mem_ctrl #(.CLK_DIV(2), .ADDR_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .spi_cs_n  (spi_cs_n),
        .spi_sck   (spi_sck),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso)
    );

`ifdef SPI_MEM_MODE_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Initial memory content, shared by the device model and the reference.
    function automatic logic [7:0] seed_byte(input logic [15:0] a);
        if (a == 16'h1234) return 8'hA5;
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // ---------------- behavioural SPI memory (mode 0) ----------------
    typedef struct {
        logic [31:0] frame;
        int          bits;
    } frame_t;

    frame_t      frames[$];
    logic [7:0]  dev_wr[int];
    logic [31:0] sl_frame = '0;
    int          sl_bits = 0;
    logic [7:0]  sl_op = '0;
    logic [7:0]  sl_rd = '0;

    always @(posedge spi_sck or negedge spi_cs_n) begin
        if (spi_sck !== 1'b1) begin
            sl_bits  = 0;
            sl_frame = '0;
        end else if (spi_cs_n === 1'b0) begin
            sl_frame = {sl_frame[30:0], spi_mosi};
            sl_bits++;
            if (sl_bits == 8) sl_op = sl_frame[7:0];
            if (sl_bits == 24)
                sl_rd = dev_wr.exists(int'(sl_frame[15:0])) ? dev_wr[int'(sl_frame[15:0])]
                                                             : seed_byte(sl_frame[15:0]);
        end
    end

    // Data changes on falling SCK; garbage outside the read data byte.
    always @(negedge spi_sck) begin
        if (spi_cs_n === 1'b0 && sl_op == 8'h03 && sl_bits >= 24 && sl_bits < 32)
            spi_miso = sl_rd[31 - sl_bits];
        else
            spi_miso = 1'($urandom);
    end

    always @(posedge spi_cs_n) begin
        frames.push_back('{sl_frame, sl_bits});
        if (sl_bits == 32 && sl_op == 8'h02)
            dev_wr[int'(sl_frame[23:8])] = sl_frame[7:0];
    end

    int mosi_err = 0;
    always @(negedge clk)
        if (spi_cs_n === 1'b1 && spi_mosi !== 1'b0) mosi_err++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model + checking ----------------
    logic [7:0] ref_mem[int];
    logic [7:0] exp_rdata = 8'h00;
    int         rd_ptr = 0;

    function automatic logic [7:0] ref_read(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : seed_byte(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns 1 ns after the accept edge.
    task automatic issue(input logic we, input logic [15:0] a, input logic [7:0] d, input bit hold);
        int g = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        while (req_ready !== 1'b1 && g < 400) begin
            @(negedge clk);
            g++;
        end
        chk("accept_bound", 32'(g < 400), 1);
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    // lat counts negedges after the accept edge; start>0 means already at that negedge.
    task automatic wait_rsp(input int start, output int lat);
        int bad = 0;
        lat = start;
        if (start == 0) begin
            @(negedge clk);
            lat = 1;
        end
        while (rsp_valid !== 1'b1 && lat < 400) begin
            if (busy !== 1'b1) bad++;
            @(negedge clk);
            lat++;
        end
        if (busy !== 1'b1) bad++;
        chk("busy_during_txn", bad, 0);
        chk("cs_high_at_rsp", spi_cs_n, 1);
        chk("sck_low_at_rsp", spi_sck, 0);
    endtask

    task automatic finish_txn(input logic we, input logic [15:0] a, input logic [7:0] d, input int lat);
        logic [31:0] ef;
        frame_t      f;
        ef = {(we ? 8'h02 : 8'h03), a, d};
        chk("latency", lat, 129);
        chk("frame_count", frames.size() - rd_ptr, 1);
        if (frames.size() > rd_ptr) begin
            f = frames[rd_ptr];
            rd_ptr++;
            chk("frame_bits", f.bits, 32);
            chk("mosi_frame", we ? f.frame : (f.frame >> 8), we ? ef : (ef >> 8));
        end
        if (we) ref_mem[int'(a)] = d;
        else    exp_rdata = ref_read(a);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
    endtask

    task automatic post_idle();
        @(negedge clk);
        chk("rsp_one_cycle", rsp_valid, 0);
        chk("ready_after_done", req_ready, 1);
        chk("cs_idle_high", spi_cs_n, 1);
    endtask

    task automatic txn(input logic we, input logic [15:0] a, input logic [7:0] d);
        int lat;
        issue(we, a, d, 1'b0);
        wait_rsp(0, lat);
        finish_txn(we, a, d, lat);
        post_idle();
    endtask

`ifdef SPI_MEM_MODE_INIT_EN
    // Called at the negedge where rst has just been released.
    task automatic init_seq();
        int     idx = 0;
        int     last_low = 0;
        int     rv = 0;
        frame_t f;
        chk("init_ready_low", req_ready, 0);
        while (req_ready !== 1'b1 && idx < 400) begin
            @(negedge clk);
            idx++;
            if (spi_cs_n === 1'b0) last_low = idx;
            if (rsp_valid === 1'b1) rv++;
        end
        chk("init_no_rsp", rv, 0);
        chk("init_ready_gap", idx - last_low, 2);
        chk("init_frame_count", frames.size() - rd_ptr, 1);
        if (frames.size() > rd_ptr) begin
            f = frames[rd_ptr];
            rd_ptr++;
            chk("init_frame_bits", f.bits, 16);
            chk("init_frame", f.frame & 32'h0000_FFFF, 32'h0000_0100);
        end
    endtask
`endif

    int         lat;
    int         g;
    int         rv;
    int         cs_cnt;
    logic       rw;
    logic [15:0] ra;
    logic [7:0] rd;
    logic [7:0] bd;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        rd_ptr = frames.size();
        chk("rst_req_ready", req_ready, INIT_EN ? 0 : 1);
        chk("rst_busy", busy, INIT_EN ? 1 : 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 8'h00);
        chk("rst_cs_n", spi_cs_n, 1);
        chk("rst_sck", spi_sck, 0);
        chk("rst_mosi", spi_mosi, 0);
        rst = 1'b0;
`ifdef SPI_MEM_MODE_INIT_EN
        init_seq();
`endif
        @(negedge clk);

        // Directed read and write
        txn(1'b0, 16'h1234, 8'h00);
        chk("read_1234_a5", rsp_rdata, 8'hA5);
        txn(1'b1, 16'hBEEF, 8'h5C);

        // Back-to-back write then read with req_valid held high
        bd = 8'($urandom);
        issue(1'b1, 16'h0010, bd, 1'b1);
        req_we    = 1'b0;
        req_wdata = 8'h00;
        wait_rsp(0, lat);
        finish_txn(1'b1, 16'h0010, bd, lat);
        cs_cnt = 0;
        g = 0;
        @(negedge clk);
        chk("b2b_ready", req_ready, 1);
        while (spi_cs_n === 1'b1 && g < 20) begin
            cs_cnt++;
            @(negedge clk);
            g++;
        end
        chk("b2b_cs_gap", cs_cnt, 1);
        req_valid = 1'b0;
        wait_rsp(1, lat);
        finish_txn(1'b0, 16'h0010, 8'h00, lat);
        chk("b2b_readback", rsp_rdata, bd);
        post_idle();

        // req_valid pulsed mid-transaction is ignored
        issue(1'b0, 16'h4321, 8'h00, 1'b0);
        repeat (40) @(negedge clk);
        chk("busy_at_pulse", busy, 1);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'h0BAD;
        req_wdata = 8'hFF;
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(41, lat);
        finish_txn(1'b0, 16'h4321, 8'h00, lat);
        post_idle();
        cs_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (spi_cs_n !== 1'b1) cs_cnt++;
        end
        chk("no_queued_txn", cs_cnt, 0);
        chk("no_extra_frame", frames.size() - rd_ptr, 0);

        // Reset at bit 12 of the address phase
        issue(1'b0, 16'h2222, 8'h00, 1'b0);
        g = 0;
        while (sl_bits != 20 && g < 400) begin
            @(negedge clk);
            g++;
        end
        chk("reach_addr_bit12", 32'(g < 400), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_cs_n", spi_cs_n, 1);
        chk("mid_rst_sck", spi_sck, 0);
        chk("mid_rst_ready", req_ready, INIT_EN ? 0 : 1);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rdata", rsp_rdata, 8'h00);
        exp_rdata = 8'h00;
        chk("aborted_frame_count", frames.size() - rd_ptr, 1);
        if (frames.size() > rd_ptr) begin
            chk("aborted_bits", frames[rd_ptr].bits, 20);
            rd_ptr++;
        end
        rst = 1'b0;
`ifdef SPI_MEM_MODE_INIT_EN
        init_seq();
`else
        rv = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) rv++;
        end
        chk("no_rsp_after_abort", rv, 0);
`endif
        @(negedge clk);
        txn(1'b0, 16'h1234, 8'h00);

        // Randomized traffic over a small address window so reads hit writes
        for (int i = 0; i < 10; i++) begin
            rw = 1'($urandom_range(0, 1));
            ra = {12'h0A5, 4'($urandom_range(0, 7))};
            rd = 8'($urandom);
            txn(rw, ra, rd);
        end

        chk("mosi_zero_when_cs_high", mosi_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
